// File: rtl/shiftreg_seq.sv
// Sequenced N-bit shift/rotate register: single-cycle HOLD/LOAD/CLR, multi-cycle
// shift, rotate and arithmetic-shift runs of up to N steps with busy/done handshake.
module shiftreg_seq #(
  parameter int N = 8,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [CW-1:0] amount,
  input  logic          shift_in,
  input  logic [N-1:0]  d,
  output logic [N-1:0]  q,
  output logic          busy,
  output logic          done,
  output logic          shift_out_left,
  output logic          shift_out_right
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_SHL  = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    op_lat, op_lat_nx;
  logic [N-1:0]  q_nx;
  logic          busy_nx, done_nx;
  logic [CW-1:0] amount_clamped;

  // One single-bit step of a shift/rotate op; non-shift codes leave the value alone.
  function automatic logic [N-1:0] step(input logic [2:0] o, input logic [N-1:0] v,
                                        input logic si);
    logic [N-1:0] r;
    case (o)
      OP_SHL:  r = {v[N-2:0], si};
      OP_SHR:  r = {si, v[N-1:1]};
      OP_ROL:  r = {v[N-2:0], v[N-1]};
      OP_ROR:  r = {v[0], v[N-1:1]};
      OP_ASR:  r = {v[N-1], v[N-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  assign amount_clamped  = (amount > CW'(N)) ? CW'(N) : amount;
  assign shift_out_left  = q[N-1];
  assign shift_out_right = q[0];

  // Next-state, counter, latched op and registered-output logic.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    op_lat_nx = op_lat;
    q_nx      = q;
    busy_nx   = busy;
    done_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        busy_nx = 1'b0;
        if (start) begin
          case (op)
            OP_HOLD: done_nx = 1'b1;
            OP_LOAD: begin
              q_nx    = d;
              done_nx = 1'b1;
            end
            OP_CLR: begin
              q_nx    = '0;
              done_nx = 1'b1;
            end
            default: begin
              if (amount == '0) begin
                done_nx = 1'b1;
              end else begin
                state_nx  = S_RUN;
                cnt_nx    = amount_clamped;
                op_lat_nx = op;
                busy_nx   = 1'b1;
              end
            end
          endcase
        end else begin
          done_nx = 1'b0;
        end
      end
      S_RUN: begin
        q_nx   = step(op_lat, q, shift_in);
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nx = S_IDLE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end else begin
          busy_nx  = 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
        busy_nx  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over any start or run step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_lat <= OP_HOLD;
      q      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      op_lat <= op_lat_nx;
      q      <= q_nx;
      busy   <= busy_nx;
      done   <= done_nx;
    end
  end

endmodule
